// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard and redirect controls from decode,
// and the IF/ID register contents handed to decode.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump_en;
    logic [25:0] jump_idx;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, misalign_err,
        input  imem_data, stall, flush, branch_taken, branch_imm, jump_en, jump_idx, jr_en, jr_target
    );

    modport slave (
        input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, misalign_err,
        output imem_data, stall, flush, branch_taken, branch_imm, jump_en, jump_idx, jr_en, jr_target
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, picks the next PC from sequential/branch/
// jump/jump-register paths and fills the IF/ID register with a retired-fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          DELAY_SLOT = 1'b0,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic [31:0] count_q;
    logic        valid_q;
    logic        err_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        misaligned;
    logic        keep_slot;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc4_q + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
    assign jump_target   = {pc4_q[31:28], bus.jump_idx, 2'b00};

    // A bubble in IF/ID cannot originate a redirect, so decode requests are gated by valid.
    assign redirect   = valid_q & (bus.jr_en | bus.branch_taken | bus.jump_en);
    assign misaligned = redirect & bus.jr_en & (bus.jr_target[1:0] != 2'b00);
    assign keep_slot  = (DELAY_SLOT != 1'b0) && !bus.flush;

    always_comb begin
        redirect_target = jump_target;
        if (bus.jr_en) begin
            redirect_target = {bus.jr_target[31:2], 2'b00};
        end else if (bus.branch_taken) begin
            redirect_target = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (misaligned) begin
                err_q <= 1'b1;
            end
            if (redirect) begin
                pc_q <= redirect_target;
                if (keep_slot) begin
                    instr_q <= bus.imem_data;
                    pc4_q   <= pc_plus4;
                    valid_q <= 1'b1;
                    count_q <= count_q + 32'd1;
                end else begin
                    instr_q <= NOP_WORD;
                    pc4_q   <= 32'd0;
                    valid_q <= 1'b0;
                end
            end else if (bus.stall) begin
                pc_q <= pc_q;
            end else if (bus.flush) begin
                pc_q    <= pc_plus4;
                instr_q <= NOP_WORD;
                pc4_q   <= 32'd0;
                valid_q <= 1'b0;
            end else begin
                pc_q    <= pc_plus4;
                instr_q <= bus.imem_data;
                pc4_q   <= pc_plus4;
                valid_q <= 1'b1;
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc           = pc_q;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_pc4    = pc4_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.fetch_count  = count_q;
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for reset/flush corners,
// and randomized traffic against a rule-level reference model, on both delay-slot variants.
module tb_fetch_stage;
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        br;
        logic [15:0] imm;
        logic        jen;
        logic [25:0] idx;
        logic        jren;
        logic [31:0] jrt;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
        logic        err;
    } st_t;

    typedef struct {
        stim_t in;
        st_t   exp;
        bit    chk_slot;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] key;
    int          n_checks = 0;
    int          n_fail = 0;
    st_t         m0;
    st_t         m1;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    fetch_stage_if bus0();
    fetch_stage_if bus1();

    fetch_stage #(.DELAY_SLOT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fetch_stage #(.DELAY_SLOT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Instruction memory returns its own address, optionally scrambled by a key.
    always_comb bus0.imem_data = bus0.imem_addr ^ key;
    always_comb bus1.imem_data = bus1.imem_addr ^ key;

    function automatic stim_t mk(logic stall, logic flush, logic br, logic [15:0] imm,
                                 logic jen, logic [25:0] idx, logic jren, logic [31:0] jrt);
        stim_t s;
        s.stall = stall; s.flush = flush; s.br = br; s.imm = imm;
        s.jen = jen; s.idx = idx; s.jren = jren; s.jrt = jrt;
        return s;
    endfunction

    function automatic st_t mkst(logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                                 logic valid, logic [31:0] count, logic err);
        st_t s;
        s.pc = pc; s.instr = instr; s.pc4 = pc4; s.valid = valid; s.count = count; s.err = err;
        return s;
    endfunction

    function automatic vec_t mkv(stim_t i, st_t e, bit slot);
        vec_t v;
        v.in = i; v.exp = e; v.chk_slot = slot;
        return v;
    endfunction

    // Reference model: one clock edge of the fetch rules in plain arithmetic.
    function automatic st_t model_step(st_t s, stim_t i, bit ds, logic [31:0] k);
        st_t         n;
        logic [31:0] word;
        logic [31:0] tgt;
        int          off;
        n    = s;
        word = s.pc ^ k;
        if (s.valid && (i.jren || i.br || i.jen)) begin
            if (i.jren) begin
                tgt = i.jrt - (i.jrt % 4);
                if (i.jrt % 4 != 0) n.err = 1'b1;
            end else if (i.br) begin
                off = int'($signed(i.imm)) * 4;
                tgt = s.pc4 + 32'(off);
            end else begin
                tgt = (s.pc4 & 32'hF000_0000) + 32'(i.idx) * 4;
            end
            n.pc = tgt;
            if (ds && !i.flush) begin
                n.instr = word; n.pc4 = s.pc + 4; n.valid = 1'b1; n.count = s.count + 1;
            end else begin
                n.instr = 32'd0; n.pc4 = 32'd0; n.valid = 1'b0;
            end
        end else if (i.stall) begin
            n = s;
        end else if (i.flush) begin
            n.pc = s.pc + 4; n.instr = 32'd0; n.pc4 = 32'd0; n.valid = 1'b0;
        end else begin
            n.pc = s.pc + 4; n.instr = word; n.pc4 = s.pc + 4; n.valid = 1'b1; n.count = s.count + 1;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(stim_t s);
        bus0.stall = s.stall; bus0.flush = s.flush; bus0.branch_taken = s.br;
        bus0.branch_imm = s.imm; bus0.jump_en = s.jen; bus0.jump_idx = s.idx;
        bus0.jr_en = s.jren; bus0.jr_target = s.jrt;
        bus1.stall = s.stall; bus1.flush = s.flush; bus1.branch_taken = s.br;
        bus1.branch_imm = s.imm; bus1.jump_en = s.jen; bus1.jump_idx = s.idx;
        bus1.jr_en = s.jren; bus1.jr_target = s.jrt;
    endtask

    task automatic applyStimulus(stim_t s);
        drive(s);
        m0 = model_step(m0, s, 1'b0, key);
        m1 = model_step(m1, s, 1'b1, key);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, bit which, st_t e);
        if (which == 1'b0) begin
            chk($sformatf("%s dut0.imem_addr", tag), bus0.imem_addr, e.pc);
            chk($sformatf("%s dut0.pc", tag), bus0.pc, e.pc);
            chk($sformatf("%s dut0.instr", tag), bus0.if_id_instr, e.instr);
            chk($sformatf("%s dut0.pc4", tag), bus0.if_id_pc4, e.pc4);
            chk($sformatf("%s dut0.valid", tag), 32'(bus0.if_id_valid), 32'(e.valid));
            chk($sformatf("%s dut0.count", tag), bus0.fetch_count, e.count);
            chk($sformatf("%s dut0.err", tag), 32'(bus0.misalign_err), 32'(e.err));
        end else begin
            chk($sformatf("%s dut1.imem_addr", tag), bus1.imem_addr, e.pc);
            chk($sformatf("%s dut1.pc", tag), bus1.pc, e.pc);
            chk($sformatf("%s dut1.instr", tag), bus1.if_id_instr, e.instr);
            chk($sformatf("%s dut1.pc4", tag), bus1.if_id_pc4, e.pc4);
            chk($sformatf("%s dut1.valid", tag), 32'(bus1.if_id_valid), 32'(e.valid));
            chk($sformatf("%s dut1.count", tag), bus1.fetch_count, e.count);
            chk($sformatf("%s dut1.err", tag), 32'(bus1.misalign_err), 32'(e.err));
        end
    endtask

    initial begin
        stim_t idle;
        stim_t s;
        st_t   rst_state;
        idle      = mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        rst_state = mkst(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Directed vectors for the delay-slot-free instance (memory word == address).
        vecs.push_back(mkv(idle, mkst(32'h4, 32'h0, 32'h4, 1, 1, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'h8, 32'h4, 32'h8, 1, 2, 0), 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkv(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0),
                               mkst(32'h8, 32'h4, 32'h8, 1, 2, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'hC, 32'h8, 32'hC, 1, 3, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'h10, 32'hC, 32'h10, 1, 4, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'h14, 32'h10, 32'h14, 1, 5, 0), 0));
        vecs.push_back(mkv(mk(0, 0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0),
                           mkst(32'h4, 32'h0, 32'h0, 0, 5, 0), 1));
        vecs.push_back(mkv(mk(0, 0, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0),
                           mkst(32'h8, 32'h4, 32'h8, 1, 6, 0), 0));
        vecs.push_back(mkv(mk(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0),
                           mkst(32'hC, 32'h0, 32'h0, 0, 6, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'h10, 32'hC, 32'h10, 1, 7, 0), 0));
        vecs.push_back(mkv(mk(0, 0, 1, 16'hFFFC, 1, 26'h40, 1, 32'h100),
                           mkst(32'h100, 32'h0, 32'h0, 0, 7, 0), 0));
        vecs.push_back(mkv(idle, mkst(32'h104, 32'h100, 32'h104, 1, 8, 0), 0));
        vecs.push_back(mkv(mk(0, 0, 0, 16'h0, 1, 26'h40, 1, 32'h103),
                           mkst(32'h100, 32'h0, 32'h0, 0, 8, 1), 0));
        vecs.push_back(mkv(idle, mkst(32'h104, 32'h100, 32'h104, 1, 9, 1), 0));
        vecs.push_back(mkv(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hA000_000C),
                           mkst(32'hA000_000C, 32'h0, 32'h0, 0, 9, 1), 0));
        vecs.push_back(mkv(idle, mkst(32'hA000_0010, 32'hA000_000C, 32'hA000_0010, 1, 10, 1), 0));
        vecs.push_back(mkv(mk(0, 0, 0, 16'h0, 1, 26'h0000040, 0, 32'h0),
                           mkst(32'hA000_0100, 32'h0, 32'h0, 0, 10, 1), 0));
        vecs.push_back(mkv(idle, mkst(32'hA000_0104, 32'hA000_0100, 32'hA000_0104, 1, 11, 1), 0));
        vecs.push_back(mkv(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC),
                           mkst(32'hFFFF_FFFC, 32'h0, 32'h0, 0, 11, 1), 0));
        vecs.push_back(mkv(idle, mkst(32'h0, 32'hFFFF_FFFC, 32'h0, 1, 12, 1), 0));
        vecs.push_back(mkv(idle, mkst(32'h4, 32'h0, 32'h4, 1, 13, 1), 0));
        vecs.push_back(mkv(mk(1, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0),
                           mkst(32'h40, 32'h0, 32'h0, 0, 13, 1), 0));

        key   = 32'h0;
        rst_n = 1'b0;
        drive(idle);
        m0 = rst_state;
        m1 = rst_state;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 0, rst_state);
        checkOutput("reset", 1, rst_state);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), 0, vecs[i].exp);
            checkOutput($sformatf("vec%0d model", i), 1, m1);
            if (vecs[i].chk_slot) begin
                chk($sformatf("vec%0d slot.instr", i), bus1.if_id_instr, 32'h14);
                chk($sformatf("vec%0d slot.pc4", i), bus1.if_id_pc4, 32'h18);
                chk($sformatf("vec%0d slot.valid", i), 32'(bus1.if_id_valid), 32'h1);
            end
        end

        // Asynchronous reset in the middle of a stall, between clock edges.
        applyStimulus(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0));
        chk("stall_hold pc", bus0.pc, 32'h40);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, rst_state);
        checkOutput("async_reset", 1, rst_state);
        m0 = rst_state;
        m1 = rst_state;
        #2;
        rst_n = 1'b1;
        drive(idle);

        // Flush coinciding with a redirect must bubble even with a delay slot.
        applyStimulus(idle);
        applyStimulus(idle);
        applyStimulus(mk(0, 1, 0, 16'h0, 0, 26'h0, 1, 32'h200));
        chk("flush_redirect dut1.pc", bus1.pc, 32'h200);
        chk("flush_redirect dut1.valid", 32'(bus1.if_id_valid), 32'h0);
        chk("flush_redirect dut1.instr", bus1.if_id_instr, 32'h0);
        chk("flush_redirect dut1.count", bus1.fetch_count, 32'h2);
        checkOutput("flush_redirect", 0, m0);
        checkOutput("flush_redirect", 1, m1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) key = $urandom;
            s.stall = ($urandom_range(0, 3) == 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.br    = ($urandom_range(0, 5) == 0);
            s.imm   = 16'($urandom);
            s.jen   = ($urandom_range(0, 7) == 0);
            s.idx   = 26'($urandom);
            s.jren  = ($urandom_range(0, 9) == 0);
            s.jrt   = $urandom;
            if ($urandom_range(0, 3) != 0) s.jrt[1:0] = 2'b00;
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", c), 0, m0);
            checkOutput($sformatf("rand%0d", c), 1, m1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Selects the next PC from the sequential, branch, jump and jump-register paths.
- Captures the returned word, with its PC+4, into the IF/ID pipeline register consumed by decode. Supports stall, flush and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DELAY_SLOT, 0, 1 = MIPS branch delay slot (instruction after a redirect is kept); 0 = that instruction is flushed
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  byte address to instruction memory; equals pc
imem_data  in  32  instruction word returned combinationally for imem_addr
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  unconditional IF/ID bubble (exception/debug); PC still advances
branch_taken  in  1  decode: conditional branch resolved taken
branch_imm  in  16  decode: signed word offset from branch instruction
jump_en  in  1  decode: J/JAL
jump_idx  in  26  decode: jump target index
jr_en  in  1  decode: JR/JALR
jr_target  in  32  decode: register-sourced byte target
pc  out  32  current fetch PC
if_id_instr  out  32  latched instruction
if_id_pc4  out  32  latched PC+4 of that instruction
if_id_valid  out  1  1 = if_id_instr is a real fetched instruction
fetch_count  out  32  number of instructions written valid into IF/ID
misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset while rst_n=0, asynchronous, any cycle including mid-stall or mid-redirect: pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, fetch_count=0, misalign_err=0.
- imem_addr = pc, combinationally. Instruction memory read is zero-latency; no wait states.
- Branch target = if_id_pc4 + (sign_extend(branch_imm) << 2).
- Jump target = {if_id_pc4[31:28], jump_idx, 2'b00}.
- All adds are 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- redirect = jr_en | branch_taken | jump_en.
- Target priority: jr_en > branch_taken > jump_en. Lower-priority requests asserted in the same cycle are ignored.
- next_pc = selected target when redirect = 1, else pc + 4.
- jr_target with bits[1:0] != 0: misalign_err sets; PC loads jr_target & ~3. Error stays set until reset.
- Per-edge update, first match wins:
  1. redirect=1 (regardless of stall): pc <= target.
     - DELAY_SLOT=0: IF/ID <= {NOP_WORD, 0, valid=0}.
     - DELAY_SLOT=1: IF/ID <= {imem_data, pc+4, valid=1}, count++.
  2. stall=1: pc, IF/ID and fetch_count hold.
  3. flush=1: pc <= pc+4; IF/ID <= {NOP_WORD, 0, valid=0}.
  4. otherwise: pc <= pc+4; IF/ID <= {imem_data, pc+4, valid=1}; fetch_count++.
- Redirect inputs are sampled only when if_id_valid=1. When valid=0 they are ignored, so no redirect ever comes from a bubble.
- flush together with redirect: redirect behaviour applies, but IF/ID is forced to a bubble even when DELAY_SLOT=1.
- fetch_count wraps 32'hFFFF_FFFF -> 0.
- Latency: a word presented at pc appears on if_id_instr one edge later. A redirect takes effect on imem_addr one edge after assertion.

Test Plan:
- Reset then release, imem returning word = addr, 4 edges -> pc 0,4,8,12,16; if_id_instr 0,4,8,12 with valid=1 from edge 1; fetch_count=4.
- stall high for 3 cycles at pc=8 -> pc stays 8, if_id_instr stays 4, count frozen; after release, sequence resumes at 8.
- if_id_pc4=0x14, branch_taken=1, branch_imm=16'hFFFC, DELAY_SLOT=0 -> pc=0x04 next edge, IF/ID bubble (valid=0, instr=NOP_WORD), count unchanged. Repeat with DELAY_SLOT=1 -> slot word latched with valid=1.
- jr_en, branch_taken and jump_en all asserted, jr_target=0x100 -> pc=0x100. Separately jr_target=0x103 -> pc=0x100 and misalign_err=1, held until rst_n pulses low.
- if_id_pc4=0xA000_0010, jump_en=1, jump_idx=26'h0000040 -> pc=0xA000_0100.
- rst_n asserted mid-stall with pc=0x40 -> all outputs return to reset values immediately, without waiting for a clock edge. Also load pc=0xFFFF_FFFC and advance one edge -> pc=0.
